if_stage_pipe: RTL

Parametrised pipelined instruction-fetch stage for the five-stage CPU. Owns the fetch PC, drives a request/ready instruction-memory port that tolerates wait states, and fills the IF/ID pipeline register with `d_pc`, `d_pc4`, `d_inst` and `d_valid`. It honours ID-stage stalls with a one-entry hold buffer and applies branch, jump and jr redirects. A parameter selects either delay-slot semantics or squash-on-redirect.

---
 rtl/if_stage_pipe.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/if_stage_pipe.sv
// Instruction fetch stage: fetch PC, imem request/ready port and IF/ID
// register, with a one-entry stall buffer and delay-slot or squash redirects.
module if_stage_pipe #(
   parameter int unsigned     XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter logic [31:0]     NOP        = 32'h0000_0000,
   parameter int unsigned     DELAY_SLOT = 1
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            stall,
   input  logic [1:0]      pcsource,
   input  logic [XLEN-1:0] bpc,
   input  logic [XLEN-1:0] rpc,
   input  logic [XLEN-1:0] jpc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   input  logic            imem_ready,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] d_pc,
   output logic [XLEN-1:0] d_pc4,
   output logic [31:0]     d_inst,
   output logic            d_valid
);

   localparam bit              DS   = (DELAY_SLOT != 0);
   localparam logic [XLEN-1:0] FOUR = XLEN'(4);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DROP  = 2'd2
   } state_t;

   state_t          state;
   logic [XLEN-1:0] f_pc;
   logic [XLEN-1:0] rp_pc;
   logic            rp_valid;
   logic [XLEN-1:0] b_pc;
   logic [31:0]     b_inst;

   logic [XLEN-1:0] tgt_raw;
   logic [XLEN-1:0] tgt;
   logic [XLEN-1:0] nxt_pc;
   logic            redir;
   logic            squash;
   logic            done;
   logic            ld_ok;
   logic [XLEN-1:0] ld_pc;
   logic [31:0]     ld_inst;

   always_comb begin
      tgt_raw = '0;
      unique case (1'b1)
         pcsource == 2'b01: tgt_raw = bpc;
         pcsource == 2'b10: tgt_raw = rpc;
         pcsource == 2'b11: tgt_raw = jpc;
         default:           tgt_raw = '0;
      endcase
   end

   assign tgt       = tgt_raw & ~XLEN'(3);
   assign redir     = (pcsource != 2'b00) && !stall;
   assign squash    = !DS && redir;
   assign imem_req  = !clr && (state != HOLD);
   assign done      = imem_req && imem_ready;
   assign imem_addr = f_pc;
   assign pc        = f_pc;

   // newest redirect wins over an older pending one
   assign nxt_pc = redir    ? tgt   :
                   rp_valid ? rp_pc :
                   f_pc + FOUR;

   always_comb begin
      ld_ok   = 1'b0;
      ld_pc   = b_pc;
      ld_inst = b_inst;
      if (state == HOLD) begin
         ld_ok = !squash;
      end else if (state == FETCH && done) begin
         ld_ok   = !squash;
         ld_pc   = f_pc;
         ld_inst = imem_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state    <= FETCH;
         f_pc     <= RESET_PC;
         rp_valid <= 1'b0;
         rp_pc    <= '0;
         b_pc     <= '0;
         b_inst   <= NOP;
         d_valid  <= 1'b0;
         d_inst   <= NOP;
         d_pc     <= '0;
         d_pc4    <= FOUR;
      end else begin
         if (!stall) begin
            d_valid <= ld_ok;
            d_inst  <= ld_ok ? ld_inst : NOP;
            if (ld_ok) begin
               d_pc  <= ld_pc;
               d_pc4 <= ld_pc + FOUR;
            end
         end
         unique case (state)
            FETCH: begin
               if (done) begin
                  f_pc     <= nxt_pc;
                  rp_valid <= 1'b0;
                  if (stall) begin
                     state  <= HOLD;
                     b_pc   <= f_pc;
                     b_inst <= imem_rdata;
                  end
               end else if (redir) begin
                  rp_valid <= 1'b1;
                  rp_pc    <= tgt;
                  if (!DS) state <= DROP;
               end
            end
            HOLD: begin
               if (!stall) begin
                  state <= FETCH;
                  if (redir) f_pc <= tgt;
               end
            end
            DROP: begin
               if (done) begin
                  state    <= FETCH;
                  rp_valid <= 1'b0;
                  f_pc     <= nxt_pc;
               end else if (redir) begin
                  rp_pc <= tgt;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule
